apb_soc_ctrl_arb: RTL
=====================

Name: apb_soc_ctrl_arb

Overview:
Two-port APB arbiter that shares the single APB slave port of the SoC control register bank between two requesters. Port 0 is the fabric controller path; port 1 is the JTAG/debug path. Arbitration is round-robin. A transfer holds the grant from its setup phase through PREADY. A watchdog ends any downstream access that never completes and returns an error to the requester, so neither requester can hang the register bank.

Parameters:
APB_ADDR_WIDTH, 12, address width on both upstream ports and the downstream port.
TIMEOUT_CYCLES, 16, number of ACCESS-state cycles before a forced error completion; 0 disables the watchdog.
ERR_RDATA, 32'hDEADBEEF, PRDATA value returned on a timeout completion.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous reset, active-low
up0_paddr  in  APB_ADDR_WIDTH  requester 0 address
up0_pwdata  in  32  requester 0 write data
up0_pwrite  in  1  requester 0 write strobe
up0_psel  in  1  requester 0 select (this is the request)
up0_penable  in  1  requester 0 enable (not used for arbitration)
up0_prdata  out  32  requester 0 read data
up0_pready  out  1  requester 0 transfer complete
up0_pslverr  out  1  requester 0 error
up1_*  same set as up0_*  requester 1
dn_paddr  out  APB_ADDR_WIDTH  to register bank
dn_pwdata  out  32  to register bank
dn_pwrite  out  1  to register bank
dn_psel  out  1  to register bank
dn_penable  out  1  to register bank
dn_prdata  in  32  from register bank
dn_pready  in  1  from register bank
dn_pslverr  in  1  from register bank
grant_o  out  1  index of the current or last grant
busy_o  out  1  high while in SETUP or ACCESS
timeout_o  out  1  one-cycle pulse on a watchdog completion

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first contention; watchdog counter 0.
- All dn_* outputs are registered. paddr, pwdata and pwrite are latched from the winner at grant and held stable until completion.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any upX_psel is high, pick the winner: on contention, the requester other than last_grant; otherwise the single requester.
  - Latch the winner's request, set dn_psel=1 and dn_penable=0, go to SETUP.
  - dn_pready is ignored in IDLE.
- SETUP: dn_penable<=1, go to ACCESS. Always exactly one cycle. dn_pready is ignored.
- ACCESS:
  - When dn_pready=1, that same cycle pass through combinationally: up[g]_pready=1, up[g]_prdata=dn_prdata, up[g]_pslverr=dn_pslverr.
  - Registered updates: dn_psel<=0, dn_penable<=0, last_grant<=g, state<=IDLE.
  - The non-granted requester sees pready=0, prdata=0, pslverr=0 throughout.
- Watchdog:
  - The counter increments each ACCESS cycle without dn_pready and clears on leaving ACCESS.
  - When the counter reaches TIMEOUT_CYCLES-1 with dn_pready still low, complete to up[g] with pready=1, pslverr=1, prdata=ERR_RDATA. Pulse timeout_o, drop dn_psel and dn_penable, go to IDLE.
  - If dn_pready and the timeout occur in the same cycle, dn_pready wins: normal completion, no timeout_o.
  - TIMEOUT_CYCLES must exceed the register bank's worst-case PREADY latency. A stale PREADY arriving after a timeout is only dropped if it lands in IDLE or SETUP.
- Latency with an idle arbiter: upX_psel sampled at edge 0; dn_psel high in cycle 1; dn_penable high in cycle 2; the register bank returns PREADY in cycle 4; upX_pready pulses in cycle 4.
  - A waiting requester is granted at the first IDLE edge after completion. With the two-cycle bank, that is a 5-cycle period per transfer.
- A requester that drops upX_psel while granted does not abort the transfer. The downstream transfer completes and the response pulse is still driven; the requester ignores it.
- Back-to-back requests from the same requester are granted consecutively only while the other requester is idle.
- Asserting HRESETn mid-transfer returns every output to 0 and state to IDLE immediately. Any in-flight transfer is abandoned.
- grant_o updates at grant and holds its value while idle.
- busy_o = (state != IDLE).

Test Plan:
- Single write: up0 writes 0x04 with 0x1C000000 -> dn_psel rises cycle 1, dn_penable cycle 2, dn_paddr=0x04, dn_pwrite=1; up0_pready one pulse in cycle 4 with pslverr=0; up1_pready stays 0.
- Single read: up1 reads 0x00, bank returns 0x00040000 -> up1_prdata=0x00040000 during its one-cycle pready; up0 outputs stay 0; grant_o=1.
- Contention: up0 and up1 assert psel in the same cycle after reset -> up0 served first, then up1. Repeat with both held -> service alternates 0,1,0,1; each transfer takes 5 cycles.
- Error passthrough: up0 reads 0x300, bank returns pslverr=1 with 0xDEADBEEF -> up0_pslverr=1, up0_prdata=0xDEADBEEF, timeout_o=0.
- Watchdog: bank never asserts pready, TIMEOUT_CYCLES=16 -> 16th ACCESS cycle gives up0_pready=1, pslverr=1, prdata=ERR_RDATA, timeout_o pulse; dn_psel=0 next cycle; a pending up1 is granted after that.
- Reset mid-transfer: HRESETn low in ACCESS -> all outputs 0 asynchronously. After release, a new up1 request completes normally; with both requesting, up0 wins first.

Source files
------------

// File: rtl/apb_soc_ctrl_arb.sv
// Round-robin arbiter sharing one APB slave port between two requesters,
// with a watchdog that force-completes downstream accesses that never finish.
module apb_soc_ctrl_arb #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] up0_paddr,
  input  logic [31:0]               up0_pwdata,
  input  logic                      up0_pwrite,
  input  logic                      up0_psel,
  input  logic                      up0_penable,
  output logic [31:0]               up0_prdata,
  output logic                      up0_pready,
  output logic                      up0_pslverr,
  input  logic [APB_ADDR_WIDTH-1:0] up1_paddr,
  input  logic [31:0]               up1_pwdata,
  input  logic                      up1_pwrite,
  input  logic                      up1_psel,
  input  logic                      up1_penable,
  output logic [31:0]               up1_prdata,
  output logic                      up1_pready,
  output logic                      up1_pslverr,
  output logic [APB_ADDR_WIDTH-1:0] dn_paddr,
  output logic [31:0]               dn_pwdata,
  output logic                      dn_pwrite,
  output logic                      dn_psel,
  output logic                      dn_penable,
  input  logic [31:0]               dn_prdata,
  input  logic                      dn_pready,
  input  logic                      dn_pslverr,
  output logic                      grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic                      last_grant_q, last_grant_d;
  logic                      dn_psel_q, dn_psel_d;
  logic                      dn_penable_q, dn_penable_d;
  logic                      dn_pwrite_q, dn_pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] dn_paddr_q, dn_paddr_d;
  logic [31:0]               dn_pwdata_q, dn_pwdata_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;

  logic        done_ok, done_tmo, win;
  logic        rsp_pready, rsp_pslverr;
  logic [31:0] rsp_prdata;
  logic        unused_penable;

  // PENABLE from the requesters carries no arbitration information.
  assign unused_penable = up0_penable ^ up1_penable;

  assign done_ok  = (state_q == ACCESS) && dn_pready;
  assign done_tmo = WD_EN && (state_q == ACCESS) && !dn_pready && (wdog_q == WD_LAST);
  // On contention the requester that was not served last wins.
  assign win      = (up0_psel && up1_psel) ? ~last_grant_q : up1_psel;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      dn_psel_q    <= 1'b0;
      dn_penable_q <= 1'b0;
      dn_pwrite_q  <= 1'b0;
      dn_paddr_q   <= '0;
      dn_pwdata_q  <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      dn_psel_q    <= dn_psel_d;
      dn_penable_q <= dn_penable_d;
      dn_pwrite_q  <= dn_pwrite_d;
      dn_paddr_q   <= dn_paddr_d;
      dn_pwdata_q  <= dn_pwdata_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    dn_psel_d    = dn_psel_q;
    dn_penable_d = dn_penable_q;
    dn_pwrite_d  = dn_pwrite_q;
    dn_paddr_d   = dn_paddr_q;
    dn_pwdata_d  = dn_pwdata_q;
    wdog_d       = '0;
    case (state_q)
      IDLE: begin
        if (up0_psel || up1_psel) begin
          grant_d      = win;
          dn_paddr_d   = win ? up1_paddr  : up0_paddr;
          dn_pwdata_d  = win ? up1_pwdata : up0_pwdata;
          dn_pwrite_d  = win ? up1_pwrite : up0_pwrite;
          dn_psel_d    = 1'b1;
          dn_penable_d = 1'b0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        dn_penable_d = 1'b1;
        state_d      = ACCESS;
      end
      ACCESS: begin
        if (done_ok || done_tmo) begin
          dn_psel_d    = 1'b0;
          dn_penable_d = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (WD_EN) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_pready  = done_ok || done_tmo;
    rsp_pslverr = done_tmo || (done_ok && dn_pslverr);
    rsp_prdata  = done_tmo ? ERR_RDATA : (done_ok ? dn_prdata : 32'h0);
    up0_pready  = 1'b0;
    up0_pslverr = 1'b0;
    up0_prdata  = 32'h0;
    up1_pready  = 1'b0;
    up1_pslverr = 1'b0;
    up1_prdata  = 32'h0;
    if (grant_q) begin
      up1_pready  = rsp_pready;
      up1_pslverr = rsp_pslverr;
      up1_prdata  = rsp_prdata;
    end else begin
      up0_pready  = rsp_pready;
      up0_pslverr = rsp_pslverr;
      up0_prdata  = rsp_prdata;
    end
    timeout_o  = done_tmo;
    busy_o     = (state_q != IDLE);
    grant_o    = grant_q;
    dn_psel    = dn_psel_q;
    dn_penable = dn_penable_q;
    dn_pwrite  = dn_pwrite_q;
    dn_paddr   = dn_paddr_q;
    dn_pwdata  = dn_pwdata_q;
  end

endmodule
